// File: rtl/subtractor_pkg.sv
// Shared constants and FSM state type for the bit-serial 4-bit subtractor.
package subtractor_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1.sv
// One-bit combinational full subtractor: d = m - s - b, bo = borrow out.
module full_subtractor_1 (
    input  logic m,
    input  logic s,
    input  logic b,
    output logic d,
    output logic bo
);

    assign d  = m ^ s ^ b;
    assign bo = (~m & s) | (~(m ^ s) & b);

endmodule

// File: rtl/subtractor_4_serial.sv
// Bit-serial subtractor with valid/ready handshakes: one bit per RUN cycle,
// LSB first, result held in DONE until the consumer takes it.
module subtractor_4_serial
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, s_q;
    logic               b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-2:0]   work_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bo_q;
    logic               bit_d, bit_bo;

    full_subtractor_1 u_fs (
        .m  (m_q[cnt_q]),
        .s  (s_q[cnt_q]),
        .b  (b_q),
        .d  (bit_d),
        .bo (bit_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = RUN;
            RUN:     if (cnt_q == LAST_BIT)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Partial difference bits shift in from the top so that, on the last bit,
    // work_q already holds bits [WIDTH-2:0] in order; diff_q only changes here.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_q    <= '0;
            s_q    <= '0;
            b_q    <= 1'b0;
            cnt_q  <= '0;
            work_q <= '0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m_q   <= minuend;
                        s_q   <= subtrahend;
                        b_q   <= borrow_in;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    b_q   <= bit_bo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        diff_q <= {bit_d, work_q};
                        bo_q   <= bit_bo;
                    end else if (WIDTH > 2) begin
                        work_q <= {bit_d, work_q[WIDTH-2:1]};
                    end else begin
                        work_q <= bit_d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bo_q;

endmodule

// File: tb/tb_subtractor_4_serial.sv
// Self-checking bench: directed cases, exhaustive sweep and random traffic
// against an arithmetic reference model of the subtractor.
module tb_subtractor_4_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] minuend;
    logic [3:0] subtrahend;
    logic       borrow_in;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] diff;
    logic       borrow_out;

    int pass_cnt  = 0;
    int check_cnt = 0;

    subtractor_4_serial #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        check_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain integer subtraction, borrow = result went negative.
    task automatic run_txn(input logic [3:0] m, input logic [3:0] s, input logic b,
                           input int stall);
        int r, exp_d, exp_bo, lat, waitc;
        r      = int'(m) - int'(s) - int'(b);
        exp_bo = (r < 0) ? 1 : 0;
        exp_d  = r & 15;

        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("in_ready_before_accept", int'(in_ready), 1);

        in_valid   = 1'b1;
        minuend    = m;
        subtrahend = s;
        borrow_in  = b;
        out_ready  = 1'($urandom);
        @(negedge clk);
        check_eq("in_ready_in_run", int'(in_ready), 0);

        lat = 1;
        while (!out_valid && lat < 20) begin
            minuend    = 4'($urandom);
            subtrahend = 4'($urandom);
            borrow_in  = 1'($urandom);
            in_valid   = 1'($urandom);
            out_ready  = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check_eq("latency", lat, 5);
        check_eq("diff", int'(diff), exp_d);
        check_eq("borrow_out", int'(borrow_out), exp_bo);
        check_eq("adder_identity", int'(diff) + int'(s) + int'(b),
                 int'(m) + 16 * int'(borrow_out));

        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0;
            @(negedge clk);
            check_eq("stall_out_valid", int'(out_valid), 1);
            check_eq("stall_in_ready", int'(in_ready), 0);
            check_eq("stall_diff", int'(diff), exp_d);
            check_eq("stall_borrow", int'(borrow_out), exp_bo);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("post_in_ready", int'(in_ready), 1);
        check_eq("post_out_valid", int'(out_valid), 0);
        check_eq("retained_diff", int'(diff), exp_d);
        $display("txn m=%0d s=%0d b=%0d -> diff=%0d bo=%0d stall=%0d",
                 m, s, b, diff, borrow_out, stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        minuend    = 4'h5;
        subtrahend = 4'h2;
        borrow_in  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_diff", int'(diff), 0);
        check_eq("rst_borrow", int'(borrow_out), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        run_txn(4'd9, 4'd3, 1'b0, 0);
        check_eq("dir_9_3_0_diff", int'(diff), 6);
        check_eq("dir_9_3_0_bo", int'(borrow_out), 0);
        run_txn(4'd3, 4'd9, 1'b0, 2);
        check_eq("dir_3_9_0_diff", int'(diff), 10);
        check_eq("dir_3_9_0_bo", int'(borrow_out), 1);
        run_txn(4'd0, 4'd0, 1'b1, 1);
        check_eq("dir_0_0_1_diff", int'(diff), 15);
        check_eq("dir_0_0_1_bo", int'(borrow_out), 1);
        run_txn(4'd15, 4'd15, 1'b1, 10);
        check_eq("dir_f_f_1_diff", int'(diff), 15);
        check_eq("dir_f_f_1_bo", int'(borrow_out), 1);

        // Reset in the second RUN cycle, with in_valid/out_ready also high.
        in_valid   = 1'b1;
        minuend    = 4'd7;
        subtrahend = 4'd1;
        borrow_in  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_eq("midrun_rst_in_ready", int'(in_ready), 1);
        check_eq("midrun_rst_out_valid", int'(out_valid), 0);
        check_eq("midrun_rst_diff", int'(diff), 0);
        check_eq("midrun_rst_borrow", int'(borrow_out), 0);
        $display("reset mid-RUN: in_ready=%0d out_valid=%0d diff=%0d",
                 in_ready, out_valid, diff);
        run_txn(4'd12, 4'd5, 1'b1, 0);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            run_txn(v[3:0], v[7:4], v[8], int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 64; i++) begin
            run_txn(4'($urandom), 4'($urandom), 1'($urandom),
                    int'($urandom_range(0, 5)));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
